// File: rtl/multiplexer_stream_nto1_pkg.sv
// Shared constants for the N:1 stream multiplexer: mode encodings, default
// sizes and a clog2 helper for tools without a working $clog2.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEFAULT_WIDTH    = 5;
    localparam int DEFAULT_CHANNELS = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/multiplexer_stream_nto1_rr_arbiter.sv
// Rotating-priority arbiter: searches req starting just after the last served
// channel and moves the pointer only when the caller reports an accepted grant.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] idx;

    // Visit rr_ptr+1 .. rr_ptr+CHANNELS (the last one is rr_ptr itself).
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = SEL_W'((int'(rr_ptr) + i) % CHANNELS);
            if (!grant_valid && req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= SEL_W'(CHANNELS - 1);
        end else if (advance) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/multiplexer_stream_nto1.sv
// N-channel stream multiplexer with a 1-entry registered output, fixed-select
// or round-robin grant. Optional packet lock is enabled by MUX_PACKET_LOCK_EN.
module multiplexer_stream_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Handshake: a word moves on channel k in any cycle where in_valid[k] and
    // in_ready[k] are both high at the rising edge; out_data moves downstream
    // when out_valid and out_ready are both high. in_ready never looks at
    // in_valid of other channels beyond the grant, and is low during reset.

    logic                load_en;
    logic                transfer;
    logic [SEL_W-1:0]    g;
    logic                grant_valid;
    logic [WIDTH-1:0]    sel_word;
    logic [CHANNELS-1:0] arb_req;
    logic [SEL_W-1:0]    arb_idx;
    logic                arb_valid;
    logic                locked;
    logic [SEL_W-1:0]    lock_ch;

`ifdef MUX_PACKET_LOCK_EN
    // Once a packet starts, it owns the output until its last word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (transfer) begin
            locked  <= !in_last[g];
            lock_ch <= g;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign locked      = 1'b0;
    assign lock_ch     = '0;
`endif

    // While locked the arbiter only sees the owning channel, so rr_ptr still
    // lands on the channel actually served.
    always_comb begin
        arb_req = in_valid;
        if (locked) begin
            arb_req = in_valid & (CHANNELS'(1) << lock_ch);
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (arb_req),
        .advance     (transfer && (mode == MODE_RR)),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        g           = '0;
        grant_valid = 1'b0;
        if (locked) begin
            g           = lock_ch;
            grant_valid = in_valid[lock_ch];
        end else if (mode == MODE_RR) begin
            g           = arb_idx;
            grant_valid = arb_valid;
        end else if (int'(select) < CHANNELS) begin
            g           = select;
            grant_valid = in_valid[select];
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign transfer = load_en && grant_valid && !rst;

    always_comb begin
        in_ready = '0;
        sel_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (g == SEL_W'(k)) begin
                in_ready[k] = transfer;
                sel_word    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A load in the same cycle as a drain simply overwrites: no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else if (transfer) begin
            out_valid   <= 1'b1;
            out_data    <= sel_word;
            out_channel <= g;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplexer_stream_nto1.sv
// Directed + randomized bench for multiplexer_stream_nto1 against a
// behavioural model; lock expectations follow MUX_PACKET_LOCK_EN.
module tb_multiplexer_stream_nto1;

    localparam int W  = 5;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [SW-1:0]   select;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_channel;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // model state
    bit        m_valid;
    int        m_data;
    int        m_chan;
    int        m_ptr;
    bit        m_locked;
    int        m_lock_ch;
    bit        last_xfer;
    int        last_g;
    logic [SW+W-1:0] exp_q[$];

    multiplexer_stream_nto1 dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .select      (select),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = 0;
        m_chan    = 0;
        m_ptr     = N - 1;
        m_locked  = 1'b0;
        m_lock_ch = 0;
        last_xfer = 1'b0;
        last_g    = 0;
        exp_q.delete();
    endtask

    task automatic model_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (m_locked) begin
            g  = m_lock_ch;
            gv = in_valid[g];
        end else if (mode) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!gv && in_valid[k]) begin
                    g  = k;
                    gv = 1'b1;
                end
            end
        end else if (int'(select) < N) begin
            g  = int'(select);
            gv = in_valid[select];
        end
    endtask

    // Called ~1 time unit after a rising edge with new inputs applied.
    task automatic step();
        int       g;
        bit       gv;
        bit       xfer;
        bit       lst;
        int       word;
        logic [N-1:0] exp_rdy;
        logic [SW+W-1:0] popped;
        #3;
        model_grant(g, gv);
        xfer    = gv && (!m_valid || out_ready);
        exp_rdy = xfer ? (N'(1) << g) : '0;
        word    = int'(in_data[g*W +: W]);
        lst     = in_last[g];
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid_pre", out_valid, m_valid);
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                popped = exp_q.pop_front();
                chk("sb_word", {out_channel, out_data}, popped);
            end
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            m_valid = 1'b1;
            m_data  = word;
            m_chan  = g;
            if (mode) m_ptr = g;
`ifdef MUX_PACKET_LOCK_EN
            m_locked  = !lst;
            m_lock_ch = g;
`endif
            exp_q.push_back({SW'(g), W'(word)});
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        last_xfer = xfer;
        last_g    = g;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_channel", out_channel, m_chan);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
    endtask

    initial begin
        int seq_a[5];
        int seq_b[4];
        int lk_exp[4];
        int lk_idx;
        int cnt1;
        int hold;
        seq_a = '{0, 1, 2, 3, 0};
        seq_b = '{1, 3, 1, 3};
`ifdef MUX_PACKET_LOCK_EN
        lk_exp = '{1, 1, 1, 2};
`else
        lk_exp = '{1, 2, 1, 2};
`endif
        rst = 1'b1; mode = 1'b0; select = '0; in_data = '0;
        in_valid = '0; in_last = '0; out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed mode, select 2, all valid
        mode = 1'b0; select = 2'd2; in_valid = '1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            in_data[2*W +: W] = 5'h0C;
            step();
            chk("fix_data", out_data, 5'h0C);
            chk("fix_chan", out_channel, 2);
            chk("fix_rdy", in_ready, 4'b0100);
        end

        // Round robin from reset
        do_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
            chk("rr_seq_all", out_channel, seq_a[c]);
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            step();
            chk("rr_seq_13", out_channel, seq_b[c]);
        end

        // Backpressure: hold 5 cycles, then resume
        in_valid = '1;
        rand_data();
        step();
        out_ready = 1'b0;
        hold = m_data;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
            chk("bp_rdy", in_ready, 0);
            chk("bp_hold", out_data, hold);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            step();
        end

        // Randomized traffic with mode / select changes
        for (int c = 0; c < 300; c++) begin
            rand_data();
            in_valid  = N'($urandom);
            in_last   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            select = SW'($urandom_range(0, N - 1));
            step();
        end

        // Packet of 3 words on ch1 competing with ch2
        out_ready = 1'b1;
        do_reset();
        mode = 1'b1; cnt1 = 0; lk_idx = 0;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            in_valid = {1'b0, 1'b1, (cnt1 < 3), 1'b0};
            in_last  = {2'b00, (cnt1 == 2), 1'b0};
            step();
            if (last_xfer && last_g == 1) cnt1++;
            if (lk_idx < 4) begin
                chk("lock_seq", out_channel, lk_exp[lk_idx]);
                lk_idx++;
            end
        end

        // Reset mid-stream with 5'h1A held
        in_last = '0;
        mode = 1'b0; select = 2'd0; in_valid = '1; out_ready = 1'b1;
        rand_data();
        in_data[0 +: W] = 5'h1A;
        step();
        out_ready = 1'b0;
        step();
        chk("hold_1a", out_data, 5'h1A);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
